pipefq: RTL and testbench
=========================

# pipefq

Instruction fetch queue between the IF stage and the IF/ID decode boundary of the pipelined CPU. It captures each fetched instruction word with its PC+4 value and presents entries to ID in order. IF can keep fetching while ID is stalled (load-use interlock). A flush on taken branch/jump discards all queued wrong-path instructions in one cycle.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- clock  in  1  pipeline clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  IF presents a fetched instruction this cycle
- in_pc4  in  32  PC+4 of the fetched instruction
- in_ins  in  32  fetched instruction word
- in_ready  out  1  queue accepts a push this cycle; drives the PC register write enable
- out_ready  in  1  ID consumes the head entry this cycle (ID not stalled)
- out_valid  out  1  head entry is valid
- out_pc4  out  32  PC+4 of head entry; 0 when empty
- out_ins  out  32  instruction of head entry; 32'h00000000 (nop) when empty
- flush  in  1  discard all entries and any same-cycle push (taken beq/bne, j, jal, jr)
- count  out  log2(DEPTH)+1  number of valid entries

## Operation
- Storage: circular buffer of DEPTH entries, 64 bits each ({pc4, ins}), with rd_ptr and wr_ptr of log2(DEPTH) bits and an occupancy counter of log2(DEPTH)+1 bits.
- Push = in_valid & in_ready & !flush. Writes at wr_ptr, then wr_ptr increments modulo DEPTH.
- Pop = out_valid & out_ready & !flush. rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH). It is independent of out_ready, so there is no combinational path from ID stall to IF.
- out_valid = (count != 0).
- out_pc4 and out_ins come from the entry at rd_ptr when valid, otherwise forced to 0. ID decodes an empty queue as a bubble.
- Occupancy update:
  - count + 1 on push only
  - count − 1 on pop only
  - unchanged on simultaneous push and pop
- Full with out_ready=1: in_ready stays 0. The pop proceeds and the push is refused, so IF holds its PC and retries next cycle.
- Empty with in_valid=1: the push is accepted. The entry becomes visible at the output the following cycle; there is no fall-through bypass.
- Flush has priority over everything. On the next edge: count=0, rd_ptr=wr_ptr=0, and no push or pop takes effect. Storage contents are left as is and are never visible because out_valid=0.
- Wrap-around: pointers roll from DEPTH−1 to 0. Full and empty are distinguished only by count, never by pointer equality.
- Reset (asynchronous, resetn=0): count=0, rd_ptr=0, wr_ptr=0, all storage entries cleared to 0. Outputs immediately become out_valid=0, out_pc4=0, out_ins=0, in_ready=1, count=0. Reset asserted mid-operation discards all entries.

## Timing
- Push-to-output latency: 1 clock. An entry pushed at edge N is presented at out_* after edge N.
- Pop takes effect at the edge; the next entry appears after that edge.
- Throughput: one push and one pop per cycle in steady state.
- in_ready, out_valid, out_pc4, out_ins and count are functions of registered state only.
- flush is sampled at the rising edge. The cycle after flush is asserted, the queue is empty and in_ready=1.
- Release from reset is synchronous in effect: the first push can occur on the first rising edge with resetn=1.

## Test plan
- Reset, then check idle outputs.
  - Stimulus: assert resetn=0 mid-cycle.
  - Response: out_valid=0, out_ins=0, out_pc4=0, in_ready=1, count=0 without waiting for a clock edge.
- Push three entries, then drain.
  - Stimulus: out_ready=0; push (pc4=0x4, ins=0x20010001), (0x8, 0x20020002), (0xC, 0x00221820); then set out_ready=1.
  - Response: count=3. Entries pop in order 0x20010001, 0x20020002, 0x00221820 on consecutive cycles, then out_valid=0 and out_ins=0.
- Fill to full.
  - Stimulus: push 4 entries (DEPTH=4) with out_ready=0, then hold in_valid=1 with a fifth word 0xDEADBEEF.
  - Response: in_ready=0 and count=4; 0xDEADBEEF is not stored.
  - Stimulus: set out_ready=1 for one cycle.
  - Response: head pops and count=3; the fifth word is accepted on the following edge.
- Simultaneous push and pop with wrap.
  - Stimulus: keep 2 entries resident; run 10 cycles with in_valid=1 and out_ready=1.
  - Response: count stays 2; outputs match inputs delayed by 2 cycles across pointer wrap.
- Flush.
  - Stimulus: with count=3, assert flush together with in_valid=1 (ins=0x08000010) and out_ready=1.
  - Response: next cycle count=0, out_valid=0, in_ready=1; 0x08000010 is never output and no pop is recorded.
- Reset mid-stream.
  - Stimulus: with count=2, pulse resetn=0 between edges.
  - Response: the queue empties immediately; the first push after release appears at the output one cycle later.

Source files
------------

// File: rtl/pipefq_if.sv
// Handshake bundle between the IF stage (master) and the fetch queue (slave).
interface pipefq_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [31:0]   in_pc4;
  logic [31:0]   in_ins;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_pc4;
  logic [31:0]   out_ins;
  logic          flush;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_pc4, in_ins, out_ready, flush,
    input  in_ready, out_valid, out_pc4, out_ins, count
  );

  modport slave (
    input  in_valid, in_pc4, in_ins, out_ready, flush,
    output in_ready, out_valid, out_pc4, out_ins, count
  );
endinterface

// File: rtl/pipefq.sv
// Instruction fetch queue between IF and the IF/ID boundary: in-order circular
// buffer of {pc4, ins}, one-cycle flush, outputs purely from registered state.
module pipefq #(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clock,
  input  logic     resetn,
  pipefq_if.slave  q
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [63:0]   head;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Ready never looks at out_ready, so an ID stall has no combinational path to IF.
  assign push = q.in_valid & ~full & ~q.flush;
  assign pop  = ~empty & q.out_ready & ~q.flush;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // One register per entry so each slot carries its own async clear.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        mem[g] <= '0;
      end else if (push && (wr_ptr == AW'(g))) begin
        mem[g] <= {q.in_pc4, q.in_ins};
      end
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    q.in_ready  = ~full;
    q.out_valid = ~empty;
    q.count     = cnt;
    q.out_pc4   = '0;
    q.out_ins   = '0;
    if (!empty) begin
      q.out_pc4 = head[63:32];
      q.out_ins = head[31:0];
    end
  end
endmodule

// File: tb/tb_pipefq.sv
// Directed bench for pipefq with a queue scoreboard of expected head entries.
module tb_pipefq;
  localparam int unsigned DEPTH = 4;

  logic clock;
  logic resetn;
  int   total;
  int   bad;
  logic [63:0] sb[$];

  pipefq_if #(.DEPTH(DEPTH)) bus ();
  pipefq #(.DEPTH(DEPTH)) dut (.clock(clock), .resetn(resetn), .q(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned n;
    n = sb.size();
    chk({tag, ".count"}, 64'(bus.count), 64'(n));
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(n != DEPTH));
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(n != 0));
    if (n != 0) begin
      chk({tag, ".head"}, {bus.out_pc4, bus.out_ins}, sb[0]);
    end else begin
      chk({tag, ".idle"}, {bus.out_pc4, bus.out_ins}, 64'h0);
    end
  endtask

  // Checks outputs against the scoreboard, predicts the edge, then advances.
  task automatic cycle(input string tag);
    bit do_push;
    bit do_pop;
    check_outputs(tag);
    do_push = bus.in_valid && (sb.size() != DEPTH) && !bus.flush;
    do_pop  = bus.out_ready && (sb.size() != 0) && !bus.flush;
    if (bus.flush) sb.delete();
    if (do_pop) void'(sb.pop_front());
    if (do_push) sb.push_back({bus.in_pc4, bus.in_ins});
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc4, input logic [31:0] ins);
    bus.in_valid = v;
    bus.in_pc4   = pc4;
    bus.in_ins   = ins;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'h0);
    chk({tag, ".out_ins"}, 64'(bus.out_ins), 64'h0);
    chk({tag, ".out_pc4"}, 64'(bus.out_pc4), 64'h0);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'h1);
    chk({tag, ".count"}, 64'(bus.count), 64'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetn = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    @(posedge clock);
    #1;
    check_idle("reset_initial");
    resetn = 1'b1;

    // First edge after release already accepts a push.
    drive(1'b1, 32'h100, 32'h11111111);
    cycle("first_push");
    drive(1'b0, 32'h0, 32'h0);
    chk("first_push.visible", 64'(bus.out_ins), 64'h11111111);
    #2 resetn = 1'b0;
    #1 check_idle("reset_midcycle");
    sb.delete();
    #1 resetn = 1'b1;
    @(posedge clock);
    #1;

    // Push three, then drain in order.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h4, 32'h20010001); cycle("p3.a");
    drive(1'b1, 32'h8, 32'h20020002); cycle("p3.b");
    drive(1'b1, 32'hC, 32'h00221820); cycle("p3.c");
    drive(1'b0, 32'h0, 32'h0);
    chk("p3.count", 64'(bus.count), 64'd3);
    bus.out_ready = 1'b1;
    chk("drain.0", 64'(bus.out_ins), 64'h20010001); cycle("drain0");
    chk("drain.1", 64'(bus.out_ins), 64'h20020002); cycle("drain1");
    chk("drain.2", 64'(bus.out_ins), 64'h00221820); cycle("drain2");
    check_idle("drain.empty");

    // Fill to full; fifth word must be held off until a pop frees a slot.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(16 + 4 * i), 32'hA0000000 + 32'(i));
      cycle("fill");
    end
    drive(1'b1, 32'h24, 32'hDEADBEEF);
    chk("full.in_ready", 64'(bus.in_ready), 64'h0);
    chk("full.count", 64'(bus.count), 64'd4);
    cycle("full.hold");
    chk("full.still", 64'(bus.count), 64'd4);
    bus.out_ready = 1'b1;
    cycle("full.pop");
    chk("full.after_pop", 64'(bus.count), 64'd3);
    bus.out_ready = 1'b0;
    cycle("full.accept");
    chk("full.refilled", 64'(bus.count), 64'd4);
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("full.drain");
    chk("full.fifth", 64'(bus.out_ins), 64'hDEADBEEF);
    cycle("full.drain_last");
    check_idle("full.empty");

    // Steady-state push+pop with two resident entries across wrap.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'hB0000000); cycle("ss.pre0");
    drive(1'b1, 32'h204, 32'hB0000001); cycle("ss.pre1");
    bus.out_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'hB0000000 + 32'(i));
      chk("ss.delay2", 64'(bus.out_ins), 64'hB0000000 + 64'(i - 2));
      cycle("ss");
      chk("ss.count", 64'(bus.count), 64'd2);
    end
    drive(1'b0, 32'h0, 32'h0);
    cycle("ss.drain0");
    cycle("ss.drain1");
    check_idle("ss.empty");

    // Flush with a same-cycle push and pop request.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'hC0000000 + 32'(i));
      cycle("fl.fill");
    end
    chk("fl.count3", 64'(bus.count), 64'd3);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h400, 32'h08000010);
    cycle("fl.edge");
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check_idle("fl.after");
    cycle("fl.quiet0");
    cycle("fl.quiet1");
    drive(1'b1, 32'h500, 32'hE0000000); cycle("fl.repush");
    drive(1'b0, 32'h0, 32'h0);
    chk("fl.repush_head", 64'(bus.out_ins), 64'hE0000000);
    cycle("fl.repush_pop");

    // Reset pulse between edges with two entries queued.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h600, 32'hF0000000); cycle("rs.fill0");
    drive(1'b1, 32'h604, 32'hF0000001); cycle("rs.fill1");
    drive(1'b0, 32'h0, 32'h0);
    chk("rs.count2", 64'(bus.count), 64'd2);
    #2 resetn = 1'b0;
    #1 check_idle("rs.async");
    sb.delete();
    #1 resetn = 1'b1;
    @(posedge clock);
    #1;
    check_idle("rs.released");
    drive(1'b1, 32'h700, 32'h12345678);
    cycle("rs.push");
    drive(1'b0, 32'h0, 32'h0);
    chk("rs.latency", {bus.out_pc4, bus.out_ins}, {32'h700, 32'h12345678});
    bus.out_ready = 1'b1;
    cycle("rs.pop");
    check_outputs("rs.final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
